lsnn_neuron_scheduler: RTL and testbench
========================================

LSNN_NEURON_SCHEDULER -- requirements
Module: lsnn_neuron_scheduler

Interface
REQ-001 Parameters: N_NEURONS, default 4, virtual neurons time-multiplexed on one update datapath.
REQ-002 Parameters: ALPHA, default 8, adaptation reset value and adaptation floor.
REQ-003 Parameters: B0, default 8, base threshold.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-005 Port: clk, in, 1, rising-edge clock.
REQ-006 Port: rst_n, in, 1, asynchronous active-high reset.
REQ-007 Port: cur_valid, in, 1, a current write is offered.
REQ-008 Port: cur_idx, in, log2(N_NEURONS), target neuron of the write.
REQ-009 Port: cur_data, in, 8, input current, unsigned.
REQ-010 Port: cur_ready, out, 1, the write is accepted; high only in IDLE.
REQ-011 Port: tick, in, 1, request one timestep sweep.
REQ-012 Port: busy, out, 1, high in UPDATE and DONE.
REQ-013 Port: spike_valid, out, 1, a per-neuron result is present.
REQ-014 Port: spike_idx, out, log2(N_NEURONS), index of the neuron the result belongs to.
REQ-015 Port: spike, out, 1, spike result of that neuron.
REQ-016 Port: thr_out, out, 8, threshold that neuron was compared against.
REQ-017 Port: spike_vec, out, N_NEURONS, spikes from the last completed sweep.
REQ-018 Port: done, out, 1, one-cycle pulse marking the end of a sweep.
REQ-019 Port: tick_overrun, out, 1, sticky flag set when a tick arrives while busy.

Function
REQ-020 Per-neuron storage SHALL hold three 8-bit values: membrane v, adaptation a and current buffer i.
REQ-021 FSM states SHALL be IDLE, UPDATE and DONE.
REQ-022 In IDLE with tick=1, the FSM SHALL go to UPDATE on the next edge with neuron counter k=0.
REQ-023 UPDATE SHALL last exactly N_NEURONS cycles and process neuron k in the k-th cycle; after k=N_NEURONS-1 it goes to DONE, and DONE goes to IDLE after 1 cycle.
REQ-024 Sweep timing SHALL be: tick sampled at edge T, UPDATE cycles T+1..T+N, DONE cycle T+N+1, and the earliest next accepted tick at edge T+N+2.
REQ-025 Update of neuron k SHALL be as follows (all unsigned, saturating at 255):
- vn = sat(i + (v>>1));
- thr = sat(B0 + a);
- s = (vn >= thr).
REQ-026 On s=1 the block SHALL write v=0 and a=sat(a + (a>>2)).
REQ-027 On s=0 the block SHALL write v=vn and a=max(ALPHA, (a>>1)+(a>>2)).
REQ-028 The current buffer i[k] SHALL be cleared to 0 in the same cycle that neuron k is updated (currents are single-use).
REQ-029 spike_valid, spike_idx, spike and thr_out SHALL be registered; the result for neuron k appears in cycle T+2+k, and spike_valid=0 otherwise.
REQ-030 spike_vec SHALL be updated atomically and become visible in the DONE cycle; done=1 only in DONE.
REQ-031 A current write SHALL occur when cur_valid && cur_ready, overwriting i[cur_idx].
REQ-032 A write and a tick on the same IDLE edge SHALL both be accepted, and the sweep SHALL use the new value.
REQ-033 A tick while busy SHALL be ignored (not queued) and SHALL set tick_overrun, which stays set until reset.
REQ-034 cur_valid while busy SHALL not be accepted (cur_ready=0); the requester holds the offer.
REQ-035 An out-of-range cur_idx (N_NEURONS not a power of 2) SHALL be accepted and discarded.

Reset
REQ-036 On reset, the block SHALL set v=0, a=ALPHA and i=0 for all neurons.
REQ-037 On reset, the FSM SHALL go to IDLE with k=0.
REQ-038 On reset, spike_valid, spike, spike_idx, thr_out, spike_vec, done, busy and tick_overrun SHALL be 0, and cur_ready SHALL be 1 once reset is released.
REQ-039 Reset asserted mid-sweep SHALL abort the sweep immediately; no partial spike_vec update is retained.

Verification
REQ-040 Scenario: write i0=20, tick -> cycle T+2 shows spike_valid=1, idx=0, spike=1, thr_out=16; then v0=0, a0=10; next tick gives idx 0, spike=0, thr_out=18, and a0 floors at 8.
REQ-041 Scenario: write i1=10 before each of 3 ticks -> v1 goes 10, 15, 17; spikes 0, 0, 1; thr_out=16 each sweep; spike_vec=4'b0010 only after sweep 3.
REQ-042 Scenario: write i2=255 before every tick for 30 sweeps -> a2 grows 8, 10, 12, 15, 18, 22, ... and saturates at 255; thr_out saturates at 255; no wrap-around.
REQ-043 Scenario: tick held high continuously with N=4 -> done pulses every 6 cycles, tick_overrun=1 after the first busy-cycle tick, and no sweep overlaps another.
REQ-044 Scenario: cur_valid with tick on the same IDLE edge (i3=40) -> neuron 3 spikes in that sweep; cur_valid during busy -> cur_ready=0 and the write lands at the first IDLE cycle.
REQ-045 Scenario: rst_n pulsed during cycle T+3 -> all outputs 0 next cycle, spike_vec stays 0, and a fresh sweep afterwards reproduces the REQ-036 reset values.

Source files
------------

// File: rtl/lsnn_neuron_scheduler.sv
// LSNN neuron scheduler: N_NEURONS adaptive leaky integrate-and-fire neurons
// time-multiplexed on a single update datapath. A tick starts one sweep that
// visits every neuron once, in index order. Each neuron holds a membrane value,
// an adaptation value and a single-use input current buffer.
module lsnn_neuron_scheduler #(
  parameter int N_NEURONS = 4,
  parameter int ALPHA     = 8,
  parameter int B0        = 8
) (
  input  logic                                         clk,
  // Active-high asynchronous reset (the name is historical).
  input  logic                                         rst_n,
  input  logic                                         cur_valid,
  input  logic [((N_NEURONS > 1) ? $clog2(N_NEURONS) : 1)-1:0] cur_idx,
  input  logic [7:0]                                   cur_data,
  output logic                                         cur_ready,
  input  logic                                         tick,
  output logic                                         busy,
  output logic                                         spike_valid,
  output logic [((N_NEURONS > 1) ? $clog2(N_NEURONS) : 1)-1:0] spike_idx,
  output logic                                         spike,
  output logic [7:0]                                   thr_out,
  output logic [N_NEURONS-1:0]                         spike_vec,
  output logic                                         done,
  output logic                                         tick_overrun
);

  localparam int IDXW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;

  localparam logic [IDXW-1:0] LAST_K = IDXW'(N_NEURONS - 1);
  localparam logic [IDXW:0]   N_EXT  = (IDXW + 1)'(N_NEURONS);
  localparam logic [7:0]      ALPHA_C = 8'(ALPHA);
  localparam logic [7:0]      B0_C    = 8'(B0);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_UPDATE = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  // ---------------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------------
  logic [1:0]           state_q, state_d;
  logic [IDXW-1:0]      k_q, k_d;
  logic [N_NEURONS-1:0] spike_acc_q, spike_acc_d;
  logic [N_NEURONS-1:0] spike_vec_q;
  logic                 spike_valid_q;
  logic [IDXW-1:0]      spike_idx_q;
  logic                 spike_q;
  logic [7:0]           thr_q;
  logic                 overrun_q;

  logic in_idle;
  logic in_update;
  logic last_k;
  logic wr_en;
  logic idx_ok;

  assign in_idle   = (state_q == S_IDLE);
  assign in_update = (state_q == S_UPDATE);
  assign last_k    = (k_q == LAST_K);
  assign wr_en     = cur_valid && cur_ready;
  // Writes to indices beyond the last neuron are accepted but dropped.
  assign idx_ok    = ({1'b0, cur_idx} < N_EXT);

  // ---------------------------------------------------------------------------
  // Shared update datapath operating on the neuron selected by k_q
  // ---------------------------------------------------------------------------
  logic [7:0] v_all [N_NEURONS];
  logic [7:0] a_all [N_NEURONS];
  logic [7:0] i_all [N_NEURONS];

  logic [7:0] sel_v, sel_a, sel_i;
  logic [8:0] vn_sum, thr_sum, a_grow_sum;
  logic [7:0] vn, thr, a_grow, a_decay_raw, a_decay;
  logic       fire;
  logic [7:0] v_new, a_new;

  assign sel_v = v_all[k_q];
  assign sel_a = a_all[k_q];
  assign sel_i = i_all[k_q];

  // Leak, integrate, threshold and adapt; every addition saturates at 255.
  always_comb begin
    vn_sum      = {1'b0, sel_i} + 9'(sel_v >> 1);
    vn          = vn_sum[8] ? 8'hFF : vn_sum[7:0];
    thr_sum     = {1'b0, B0_C} + {1'b0, sel_a};
    thr         = thr_sum[8] ? 8'hFF : thr_sum[7:0];
    fire        = (vn >= thr);
    a_grow_sum  = {1'b0, sel_a} + 9'(sel_a >> 2);
    a_grow      = a_grow_sum[8] ? 8'hFF : a_grow_sum[7:0];
    // a/2 + a/4 never exceeds 190, so no saturation is needed on decay.
    a_decay_raw = (sel_a >> 1) + (sel_a >> 2);
    a_decay     = (a_decay_raw < ALPHA_C) ? ALPHA_C : a_decay_raw;
    v_new       = fire ? 8'd0 : vn;
    a_new       = fire ? a_grow : a_decay;
  end

  // ---------------------------------------------------------------------------
  // Per-neuron storage
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < N_NEURONS; gi++) begin : g_neuron
      logic [7:0] v_q, a_q, i_q;
      logic       sel_upd;
      logic       sel_wr;

      assign sel_upd = in_update && (k_q == IDXW'(gi));
      assign sel_wr  = wr_en && idx_ok && (cur_idx == IDXW'(gi));

      // Neuron state takes the datapath result when visited; the current is
      // consumed on that visit and otherwise overwritten by accepted writes.
      always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
          v_q <= 8'd0;
          a_q <= ALPHA_C;
          i_q <= 8'd0;
        end else begin
          if (sel_upd) begin
            v_q <= v_new;
            a_q <= a_new;
          end
          if (sel_upd) begin
            i_q <= 8'd0;
          end else if (sel_wr) begin
            i_q <= cur_data;
          end
        end
      end

      assign v_all[gi] = v_q;
      assign a_all[gi] = a_q;
      assign i_all[gi] = i_q;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Sweep sequencing
  // ---------------------------------------------------------------------------

  // Next state, neuron counter and the spike accumulator for the running sweep.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    spike_acc_d = spike_acc_q;
    case (state_q)
      S_IDLE: begin
        if (tick) begin
          state_d     = S_UPDATE;
          k_d         = '0;
          spike_acc_d = '0;
        end
      end
      S_UPDATE: begin
        spike_acc_d[k_q] = fire;
        if (last_k) begin
          state_d = S_DONE;
          k_d     = '0;
        end else begin
          k_d = k_q + IDXW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        k_d     = '0;
      end
    endcase
  end

  // Registers the FSM, per-neuron result stream, sweep spike vector and the
  // sticky overrun flag. spike_vec is loaded only from the final update, so an
  // aborted sweep never leaves a partial vector behind.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q       <= S_IDLE;
      k_q           <= '0;
      spike_acc_q   <= '0;
      spike_vec_q   <= '0;
      spike_valid_q <= 1'b0;
      spike_idx_q   <= '0;
      spike_q       <= 1'b0;
      thr_q         <= 8'd0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      k_q           <= k_d;
      spike_acc_q   <= spike_acc_d;
      spike_valid_q <= in_update;
      if (in_update) begin
        spike_idx_q <= k_q;
        spike_q     <= fire;
        thr_q       <= thr;
      end
      if (in_update && last_k) begin
        spike_vec_q <= spike_acc_d;
      end
      if (tick && !in_idle) begin
        overrun_q <= 1'b1;
      end
    end
  end

  // Writes are only taken between sweeps and never while reset is held.
  assign cur_ready    = in_idle && !rst_n;
  assign busy         = !in_idle;
  assign done         = (state_q == S_DONE);
  assign spike_valid  = spike_valid_q;
  assign spike_idx    = spike_idx_q;
  assign spike        = spike_q;
  assign thr_out      = thr_q;
  assign spike_vec    = spike_vec_q;
  assign tick_overrun = overrun_q;

endmodule

// File: tb/tb_lsnn_neuron_scheduler.sv
// Self-checking bench for lsnn_neuron_scheduler: a table of scripted sweeps,
// hand-written multi-cycle corner cases and randomized sweeps, all compared
// against a sweep-level arithmetic model of the neuron population.
module tb_lsnn_neuron_scheduler;

  localparam int N     = 4;
  localparam int ALPHA = 8;
  localparam int B0    = 8;
  localparam int IDXW  = 2;

  logic            clk;
  logic            rst_n;
  logic            cur_valid;
  logic [IDXW-1:0] cur_idx;
  logic [7:0]      cur_data;
  logic            cur_ready;
  logic            tick;
  logic            busy;
  logic            spike_valid;
  logic [IDXW-1:0] spike_idx;
  logic            spike;
  logic [7:0]      thr_out;
  logic [N-1:0]    spike_vec;
  logic            done;
  logic            tick_overrun;

  lsnn_neuron_scheduler #(.N_NEURONS(N), .ALPHA(ALPHA), .B0(B0)) dut (
    .clk(clk), .rst_n(rst_n),
    .cur_valid(cur_valid), .cur_idx(cur_idx), .cur_data(cur_data), .cur_ready(cur_ready),
    .tick(tick), .busy(busy),
    .spike_valid(spike_valid), .spike_idx(spike_idx), .spike(spike), .thr_out(thr_out),
    .spike_vec(spike_vec), .done(done), .tick_overrun(tick_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_sweep = 0;

  // Behavioural model state (plain integers)
  int mv[N];
  int ma[N];
  int mi[N];
  int exp_s[N];
  int exp_thr[N];
  int exp_vec;

  // Observed results of the most recent checked sweep
  int obs_s[N];
  int obs_thr[N];
  int obs_vec;

  typedef struct {
    int pre_idx;    // neuron written in IDLE before the tick (-1: none)
    int same_idx;   // neuron written on the tick edge itself (-1: none)
    int val;
    int chk_idx;
    int exp_spike;
    int exp_thr;
    int exp_vec;
  } vec_t;

  vec_t tbl[6];

  function automatic int sat(input int x);
    return (x > 255) ? 255 : x;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      mv[k] = 0;
      ma[k] = ALPHA;
      mi[k] = 0;
    end
  endtask

  // One whole timestep applied to the model population.
  task automatic model_sweep();
    int vn;
    int thr;
    int dec;
    exp_vec = 0;
    for (int k = 0; k < N; k++) begin
      vn  = sat(mi[k] + mv[k] / 2);
      thr = sat(B0 + ma[k]);
      exp_thr[k] = thr;
      exp_s[k]   = (vn >= thr) ? 1 : 0;
      if (vn >= thr) begin
        mv[k] = 0;
        ma[k] = sat(ma[k] + ma[k] / 4);
        exp_vec = exp_vec | (1 << k);
      end else begin
        mv[k] = vn;
        dec   = ma[k] / 2 + ma[k] / 4;
        ma[k] = (dec > ALPHA) ? dec : ALPHA;
      end
      mi[k] = 0;
    end
  endtask

  // Single IDLE-cycle current write.
  task automatic wr(input int idx, input int val);
    cur_valid = 1'b1;
    cur_idx   = IDXW'(idx);
    cur_data  = 8'(val);
    chk("cur_ready_idle", int'(cur_ready), 1);
    step();
    cur_valid = 1'b0;
    mi[idx] = val;
  endtask

  // Tick from IDLE (optionally with a same-edge write) and check every cycle
  // of the sweep until the block is back in IDLE.
  task automatic run_sweep(input int widx, input int wval);
    if (widx >= 0) begin
      cur_valid = 1'b1;
      cur_idx   = IDXW'(widx);
      cur_data  = 8'(wval);
      mi[widx]  = wval;
    end
    tick = 1'b1;
    step();
    tick = 1'b0;
    cur_valid = 1'b0;
    model_sweep();
    chk("busy_first", int'(busy), 1);
    chk("valid_first", int'(spike_valid), 0);
    for (int j = 0; j < N; j++) begin
      step();
      obs_s[j]   = int'(spike);
      obs_thr[j] = int'(thr_out);
      chk($sformatf("valid_n%0d", j), int'(spike_valid), 1);
      chk($sformatf("idx_n%0d", j), int'(spike_idx), j);
      chk($sformatf("spike_n%0d", j), obs_s[j], exp_s[j]);
      chk($sformatf("thr_n%0d", j), obs_thr[j], exp_thr[j]);
      chk($sformatf("done_n%0d", j), int'(done), (j == N - 1) ? 1 : 0);
      if (j == N - 1) begin
        obs_vec = int'(spike_vec);
        chk("spike_vec", obs_vec, exp_vec);
      end
    end
    step();
    chk("done_after", int'(done), 0);
    chk("busy_after", int'(busy), 0);
    chk("valid_after", int'(spike_valid), 0);
    chk("ready_after", int'(cur_ready), 1);
    n_sweep++;
    $display("sweep %0d: spikes=%b thr=%0d/%0d/%0d/%0d", n_sweep, spike_vec,
             obs_thr[0], obs_thr[1], obs_thr[2], obs_thr[3]);
  endtask

  initial begin
    // Scripted sweeps from reset: {pre, same, val, chk_idx, spike, thr, vec}
    tbl[0] = '{0, -1, 20, 0, 1, 16, 4'b0001};
    tbl[1] = '{-1, -1, 0, 0, 0, 18, 4'b0000};
    tbl[2] = '{1, -1, 10, 1, 0, 16, 4'b0000};
    tbl[3] = '{1, -1, 10, 1, 0, 16, 4'b0000};
    tbl[4] = '{1, -1, 10, 1, 1, 16, 4'b0010};
    tbl[5] = '{-1, 3, 40, 3, 1, 16, 4'b1000};

    rst_n     = 1'b1;
    cur_valid = 1'b0;
    cur_idx   = '0;
    cur_data  = 8'd0;
    tick      = 1'b0;
    model_reset();
    repeat (3) step();
    rst_n = 1'b0;
    step();

    // Reset state
    chk("rst_valid", int'(spike_valid), 0);
    chk("rst_spike", int'(spike), 0);
    chk("rst_idx", int'(spike_idx), 0);
    chk("rst_thr", int'(thr_out), 0);
    chk("rst_vec", int'(spike_vec), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overrun", int'(tick_overrun), 0);
    chk("rst_ready", int'(cur_ready), 1);

    // Table-driven scripted sweeps
    for (int r = 0; r < 6; r++) begin
      if (tbl[r].pre_idx >= 0) wr(tbl[r].pre_idx, tbl[r].val);
      run_sweep(tbl[r].same_idx, tbl[r].val);
      chk($sformatf("tbl%0d_spike", r), obs_s[tbl[r].chk_idx], tbl[r].exp_spike);
      chk($sformatf("tbl%0d_thr", r), obs_thr[tbl[r].chk_idx], tbl[r].exp_thr);
      chk($sformatf("tbl%0d_vec", r), obs_vec, tbl[r].exp_vec);
    end
    // Adaptation of neuron 0 has decayed back to its floor
    chk("a0_floor_thr", obs_thr[0], B0 + ALPHA);

    // Saturation: maximal current into neuron 2 every sweep
    for (int s = 0; s < 30; s++) begin
      wr(2, 255);
      run_sweep(-1, 0);
    end
    chk("sat_thr2", obs_thr[2], 255);
    chk("sat_spike2", obs_s[2], 1);

    // Tick held high: sweeps back to back, never overlapping
    chk("overrun_before", int'(tick_overrun), 0);
    tick = 1'b1;
    for (int c = 1; c <= 23; c++) begin
      step();
      chk($sformatf("cont_busy_c%0d", c), int'(busy), (c % 6 != 0) ? 1 : 0);
      chk($sformatf("cont_done_c%0d", c), int'(done), (c % 6 == 5) ? 1 : 0);
    end
    tick = 1'b0;
    step();
    repeat (4) model_sweep();
    chk("overrun_after", int'(tick_overrun), 1);
    chk("cont_vec", int'(spike_vec), exp_vec);
    chk("cont_idle", int'(busy), 0);

    // Write offered while busy waits until IDLE
    tick = 1'b1;
    step();
    tick = 1'b0;
    cur_valid = 1'b1;
    cur_idx   = 2'd3;
    cur_data  = 8'd40;
    for (int c = 1; c <= N + 1; c++) begin
      chk($sformatf("busy_ready_c%0d", c), int'(cur_ready), 0);
      step();
    end
    chk("ready_reopen", int'(cur_ready), 1);
    step();
    cur_valid = 1'b0;
    model_sweep();
    mi[3] = 40;
    run_sweep(-1, 0);

    // Reset in the middle of a sweep
    cur_valid = 1'b1;
    cur_idx   = 2'd0;
    cur_data  = 8'd200;
    tick      = 1'b1;
    step();
    tick      = 1'b0;
    cur_valid = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    #2;
    chk("mid_rst_valid", int'(spike_valid), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_vec", int'(spike_vec), 0);
    chk("mid_rst_thr", int'(thr_out), 0);
    chk("mid_rst_overrun", int'(tick_overrun), 0);
    #1;
    rst_n = 1'b0;
    model_reset();
    step();
    chk("post_rst_ready", int'(cur_ready), 1);
    chk("post_rst_vec", int'(spike_vec), 0);
    run_sweep(0, 20);
    chk("fresh_thr0", obs_thr[0], 16);
    chk("fresh_thr1", obs_thr[1], 16);
    chk("fresh_spike0", obs_s[0], 1);

    // Randomized sweeps against the model
    for (int r = 0; r < 40; r++) begin
      int nw;
      nw = int'($urandom_range(0, 3));
      for (int w = 0; w < nw; w++) begin
        wr(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 255)));
      end
      if ($urandom_range(0, 1) == 1)
        run_sweep(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 255)));
      else
        run_sweep(-1, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
